// File: rtl/dmem_arb_pkg.sv
// Shared types and decode constants for the data-memory / IO bus arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam int IO_SEL_BIT = 7;
    localparam int IO_REG_LSB = 2;

    // Byte address must be word aligned for any bus access to happen.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_io_arbiter_if.sv
// Bundle of both master ports plus the dmem and IO buses around the arbiter.
interface dmem_io_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic          a_err;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic          b_err;
    logic [DW-1:0] b_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          io_sel;
    logic          io_we;
    logic [1:0]    io_reg;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_err, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_err, b_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output io_sel, io_we, io_reg, io_wdata,
        input  io_rdata
    );

    // Environment side: masters plus the dmem / IO devices.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_err, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_err, b_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  io_sel, io_we, io_reg, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_io_arbiter.sv
// Shares one dmem/IO bus between port A (CPU) and port B (debug loader):
// arbitrate, decode, perform one access, then pulse a one-cycle ack.
module dmem_io_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int IO_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_io_arbiter_if.slave bus
);

    localparam logic [3:0] WAIT_LOAD = 4'(IO_WAIT - 1);

    state_t        r_state;
    logic          r_last;      // port granted most recently, 1 = B
    logic          r_owner;     // port owning the current transfer, 1 = B
    logic          r_we;
    logic          r_is_io;
    logic [3:0]    r_cnt;

    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_io_sel;
    logic          r_io_we;
    logic [1:0]    r_io_reg;
    logic [DW-1:0] r_io_wdata;

    logic          r_ack   [2];
    logic          r_err   [2];
    logic [DW-1:0] r_rdata [2];

    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_win;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wdata;

    assign w_req = {bus.b_req, bus.a_req};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign w_win       = w_gnt[1];
    assign w_win_we    = w_win ? bus.b_we    : bus.a_we;
    assign w_win_addr  = w_win ? bus.b_addr  : bus.a_addr;
    assign w_win_wdata = w_win ? bus.b_wdata : bus.a_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_is_io     <= 1'b0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_io_sel    <= 1'b0;
            r_io_we     <= 1'b0;
            r_io_reg    <= '0;
            r_io_wdata  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_ack[i]   <= 1'b0;
                r_err[i]   <= 1'b0;
                r_rdata[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_owner <= w_win;
                        r_we    <= w_win_we;
                        r_is_io <= w_win_addr[IO_SEL_BIT];
                        if (is_misaligned(w_win_addr[1:0])) begin
                            r_ack[w_win]   <= 1'b1;
                            r_err[w_win]   <= 1'b1;
                            r_rdata[w_win] <= '0;
                            r_state        <= RESP;
                        end else if (w_win_addr[IO_SEL_BIT]) begin
                            r_io_sel   <= 1'b1;
                            r_io_reg   <= w_win_addr[IO_REG_LSB +: 2];
                            r_io_wdata <= w_win_wdata;
                            r_io_we    <= w_win_we && (WAIT_LOAD == 4'd0);
                            r_cnt      <= WAIT_LOAD;
                            r_state    <= ACCESS;
                        end else begin
                            r_mem_we    <= w_win_we;
                            r_mem_addr  <= w_win_addr;
                            r_mem_wdata <= w_win_wdata;
                            r_state     <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (!r_is_io) begin
                        r_ack[r_owner]   <= 1'b1;
                        r_rdata[r_owner] <= r_we ? '0 : bus.mem_rdata;
                        r_mem_we         <= 1'b0;
                        r_mem_addr       <= '0;
                        r_mem_wdata      <= '0;
                        r_state          <= RESP;
                    end else if (r_cnt == 4'd0) begin
                        r_ack[r_owner]   <= 1'b1;
                        r_rdata[r_owner] <= r_we ? '0 : bus.io_rdata;
                        r_io_sel         <= 1'b0;
                        r_io_we          <= 1'b0;
                        r_io_reg         <= '0;
                        r_io_wdata       <= '0;
                        r_state          <= RESP;
                    end else begin
                        // Write strobe lands only in the last wait cycle.
                        r_cnt   <= r_cnt - 4'd1;
                        r_io_we <= r_we && (r_cnt == 4'd1);
                    end
                end

                RESP: begin
                    for (int i = 0; i < 2; i++) begin
                        r_ack[i]   <= 1'b0;
                        r_err[i]   <= 1'b0;
                        r_rdata[i] <= '0;
                    end
                    r_last  <= r_owner;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a_ack     = r_ack[0];
    assign bus.a_err     = r_err[0];
    assign bus.a_rdata   = r_rdata[0];
    assign bus.b_ack     = r_ack[1];
    assign bus.b_err     = r_err[1];
    assign bus.b_rdata   = r_rdata[1];

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.io_sel    = r_io_sel;
    assign bus.io_we     = r_io_we;
    assign bus.io_reg    = r_io_reg;
    assign bus.io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Randomized bench for dmem_io_arbiter against a transaction-level reference model.
module tb_dmem_io_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int IO_WAIT = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        port;
        logic [31:0] edge_n;
        logic [31:0] rdata;
        logic        err;
    } ack_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_io_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    dmem_io_arbiter #(.DW(DW), .AW(AW), .IO_WAIT(IO_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Device models attached to the bus.
    logic [31:0] dmem    [32];
    logic [31:0] io_regs [4];
    assign bus.mem_rdata = dmem[bus.mem_addr[6:2]];
    assign bus.io_rdata  = io_regs[bus.io_reg];
    always @(posedge clk) begin
        if (bus.mem_we) dmem[bus.mem_addr[6:2]] <= bus.mem_wdata;
        if (bus.io_we)  io_regs[bus.io_reg]     <= bus.io_wdata;
    end

    // Reference model state.
    logic [31:0] sh_mem [32];
    logic [31:0] sh_io  [4];
    logic        model_last;

    txn_t qa[$];
    txn_t qb[$];
    ack_t exp_q[$];
    ack_t obs_q[$];
    int   exp_io_cyc, exp_io_we, exp_mem_cyc, exp_mem_we;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Walks both request queues as the arbitration rules dictate and
    // predicts every ack: port, cycle, data, error.
    task automatic predict();
        int   e, ia, ib, lat;
        logic w;
        txn_t t;
        ack_t ev;
        e = 1; ia = 0; ib = 0;
        exp_q.delete();
        exp_io_cyc = 0; exp_io_we = 0; exp_mem_cyc = 0; exp_mem_we = 0;
        while (ia < qa.size() || ib < qb.size()) begin
            if (ia < qa.size() && ib < qb.size()) w = model_last ? 1'b0 : 1'b1;
            else                                   w = (ia < qa.size()) ? 1'b0 : 1'b1;
            if (w) begin t = qb[ib]; ib++; end
            else   begin t = qa[ia]; ia++; end
            ev.port  = w;
            ev.err   = (t.addr[1:0] != 2'b00);
            ev.rdata = '0;
            if (ev.err) begin
                lat = 1;
            end else if (t.addr[7]) begin
                lat = IO_WAIT + 1;
                exp_io_cyc += IO_WAIT;
                if (t.we) begin sh_io[t.addr[3:2]] = t.wdata; exp_io_we++; end
                else ev.rdata = sh_io[t.addr[3:2]];
            end else begin
                lat = 2;
                exp_mem_cyc++;
                if (t.we) begin sh_mem[t.addr[6:2]] = t.wdata; exp_mem_we++; end
                else ev.rdata = sh_mem[t.addr[6:2]];
            end
            ev.edge_n = 32'(e + lat - 1);
            exp_q.push_back(ev);
            model_last = w;
            e = e + lat + 1;
        end
    endtask

    task automatic drive_idle();
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic run_scenario(input string name);
        int   pa, pb, edge_n, io_cyc, io_we_n, mem_cyc, mem_we_n, viol;
        ack_t ev;
        pa = 0; pb = 0; edge_n = 0;
        io_cyc = 0; io_we_n = 0; mem_cyc = 0; mem_we_n = 0; viol = 0;
        obs_q.delete();
        predict();
        @(negedge clk);
        if (qa.size() > 0) begin
            bus.a_req = 1'b1; bus.a_we = qa[0].we; bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata;
        end
        if (qb.size() > 0) begin
            bus.b_req = 1'b1; bus.b_we = qb[0].we; bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata;
        end
        while ((pa < qa.size() || pb < qb.size()) && edge_n < 400) begin
            @(negedge clk);
            edge_n++;
            if (bus.io_sel) io_cyc++;
            if (bus.io_we) io_we_n++;
            if (bus.mem_we) mem_we_n++;
            if (bus.mem_we || bus.mem_addr != '0) mem_cyc++;
            if (bus.io_we && !bus.io_sel) viol++;
            if ((bus.mem_we || bus.mem_addr != '0) && bus.io_sel) viol++;
            if (bus.a_ack && bus.b_ack) viol++;
            if (bus.a_ack) begin
                ev.port = 1'b0; ev.edge_n = 32'(edge_n); ev.rdata = bus.a_rdata; ev.err = bus.a_err;
                obs_q.push_back(ev);
                pa++;
                if (pa < qa.size()) begin
                    bus.a_we = qa[pa].we; bus.a_addr = qa[pa].addr; bus.a_wdata = qa[pa].wdata;
                end else bus.a_req = 1'b0;
            end
            if (bus.b_ack) begin
                ev.port = 1'b1; ev.edge_n = 32'(edge_n); ev.rdata = bus.b_rdata; ev.err = bus.b_err;
                obs_q.push_back(ev);
                pb++;
                if (pb < qb.size()) begin
                    bus.b_we = qb[pb].we; bus.b_addr = qb[pb].addr; bus.b_wdata = qb[pb].wdata;
                end else bus.b_req = 1'b0;
            end
        end
        drive_idle();
        repeat (3) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack || bus.io_sel || bus.mem_we) viol++;
        end
        check_val({name, " timeout"}, 64'(edge_n >= 400), 64'd0);
        check_val({name, " ack_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            $display("%s txn %0d: port %s edge %0d rdata 0x%08h err %0d",
                     name, i, obs_q[i].port ? "B" : "A", obs_q[i].edge_n, obs_q[i].rdata, obs_q[i].err);
            check_val({name, " port"},  64'(obs_q[i].port),   64'(exp_q[i].port));
            check_val({name, " edge"},  64'(obs_q[i].edge_n), 64'(exp_q[i].edge_n));
            check_val({name, " rdata"}, 64'(obs_q[i].rdata),  64'(exp_q[i].rdata));
            check_val({name, " err"},   64'(obs_q[i].err),    64'(exp_q[i].err));
        end
        check_val({name, " io_sel_cycles"}, 64'(io_cyc),   64'(exp_io_cyc));
        check_val({name, " io_we_pulses"},  64'(io_we_n),  64'(exp_io_we));
        check_val({name, " mem_cycles"},    64'(mem_cyc),  64'(exp_mem_cyc));
        check_val({name, " mem_we_pulses"}, 64'(mem_we_n), 64'(exp_mem_we));
        check_val({name, " protocol"},      64'(viol),     64'd0);
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   k;
        k       = $urandom_range(0, 9);
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        if (k < 5)      t.addr = 32'($urandom_range(1, 31)) << 2;
        else if (k < 8) t.addr = 32'h80 | (32'($urandom_range(0, 3)) << 2);
        else            t.addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        return t;
    endfunction

    initial begin
        int viol_rst;
        for (int i = 0; i < 32; i++) begin
            dmem[i]   = $urandom;
            sh_mem[i] = dmem[i];
        end
        for (int i = 0; i < 4; i++) begin
            io_regs[i] = '0;
            sh_io[i]   = '0;
        end
        dmem[4]   = 32'hDEADBEEF;
        sh_mem[4] = 32'hDEADBEEF;
        drive_idle();
        reset      = 1'b0;
        model_last = 1'b1;
        #1;
        check_val("rst a_ack",    64'(bus.a_ack),    64'd0);
        check_val("rst b_ack",    64'(bus.b_ack),    64'd0);
        check_val("rst mem_we",   64'(bus.mem_we),   64'd0);
        check_val("rst mem_addr", 64'(bus.mem_addr), 64'd0);
        check_val("rst io_sel",   64'(bus.io_sel),   64'd0);
        check_val("rst io_we",    64'(bus.io_we),    64'd0);
        do_reset();

        qa = '{mk(1'b0, 32'h10, 32'h0)}; qb = '{};
        run_scenario("a_read_dmem");

        qa = '{}; qb = '{mk(1'b1, 32'h84, 32'h1234)};
        run_scenario("b_write_io");
        check_val("io_reg1 value", 64'(io_regs[1]), 64'h1234);

        // Reset in the second IO access cycle of a write.
        qa = '{}; qb = '{};
        @(negedge clk);
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 32'h88; bus.b_wdata = 32'h5555;
        @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_val("midrst io_sel", 64'(bus.io_sel), 64'd0);
        check_val("midrst io_we",  64'(bus.io_we),  64'd0);
        check_val("midrst b_ack",  64'(bus.b_ack),  64'd0);
        drive_idle();
        viol_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.io_we || bus.b_ack || bus.io_sel) viol_rst++;
        end
        reset = 1'b1;
        model_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.io_we || bus.b_ack || bus.io_sel) viol_rst++;
        end
        check_val("midrst quiet", 64'(viol_rst), 64'd0);
        check_val("midrst io_reg2", 64'(io_regs[2]), 64'(sh_io[2]));

        qa = '{mk(1'b0, 32'h10, 32'h0)}; qb = '{mk(1'b0, 32'h84, 32'h0)};
        run_scenario("tie_from_reset");
        qa = '{mk(1'b0, 32'h20, 32'h0)}; qb = '{mk(1'b0, 32'h24, 32'h0)};
        run_scenario("tie_again");

        qa = '{mk(1'b1, 32'h13, 32'hCAFE)}; qb = '{};
        run_scenario("misaligned");

        do_reset();
        qa = '{mk(1'b1, 32'h30, 32'hA1), mk(1'b0, 32'h30, 32'h0)};
        qb = '{mk(1'b1, 32'h8C, 32'hB2)};
        run_scenario("a_held_req");

        for (int s = 0; s < 25; s++) begin
            int na, nb;
            na = $urandom_range(0, 3);
            nb = (na == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            qa = '{}; qb = '{};
            for (int i = 0; i < na; i++) qa.push_back(rand_txn());
            for (int i = 0; i < nb; i++) qb.push_back(rand_txn());
            run_scenario($sformatf("rand%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
